// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: FSM states and decimal constants.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W:0]   BCD_TEN = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when a 4-bit nibble is not a legal BCD digit.
    function automatic logic is_bad_digit(input logic [DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Request/response bundle of the serial BCD adder: operands in, packed BCD result out.
interface bcd_serial_adder_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = 4 * DIGITS;

    logic         start_valid;
    logic         start_ready;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         neg;
    logic         invalid;

    modport master (
        output start_valid, sub, a, b, done_ready,
        input  start_ready, done_valid, result, carry_out, neg, invalid
    );

    modport slave (
        input  start_valid, sub, a, b, done_ready,
        output start_ready, done_valid, result, carry_out, neg, invalid
    );
endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder; in subtract mode b is nine's-complemented.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               sub,
    input  logic               cin,
    output logic [DIGIT_W-1:0] digit,
    output logic               cout,
    output logic               bad_digit
);
    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   sum;

    always_comb begin
        b_eff     = sub ? DIGIT_W'(BCD_MAX - b_d) : b_d;
        sum       = (DIGIT_W+1)'(a_d) + (DIGIT_W+1)'(b_eff) + (DIGIT_W+1)'(cin);
        cout      = sum > (DIGIT_W+1)'(BCD_MAX);
        digit     = cout ? DIGIT_W'(sum - BCD_TEN) : sum[DIGIT_W-1:0];
        bad_digit = is_bad_digit(a_d) || is_bad_digit(b_d);
    end
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD add/subtract: one digit per cycle, LSD first, ten's-complement subtraction.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_serial_adder_if.slave    bus
);
    localparam int unsigned W     = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state;
    logic [W-1:0]       a_sr;
    logic [W-1:0]       b_sr;
    logic [W-1:0]       acc;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               sub_q;
    logic               bad;

    logic [DIGIT_W-1:0] dig;
    logic               dcout;
    logic               dbad;
    logic [W-1:0]       acc_nxt;
    logic               bad_nxt;
    logic               last;

    bcd_digit_add u_digit (
        .a_d       (a_sr[DIGIT_W-1:0]),
        .b_d       (b_sr[DIGIT_W-1:0]),
        .sub       (sub_q),
        .cin       (carry),
        .digit     (dig),
        .cout      (dcout),
        .bad_digit (dbad)
    );

    // New digit enters at the top so digit 0 lands in bits [3:0] after the last shift.
    assign acc_nxt = W'({dig, acc} >> DIGIT_W);
    assign bad_nxt = bad | dbad;
    assign last    = (cnt == CNT_W'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            a_sr            <= '0;
            b_sr            <= '0;
            acc             <= '0;
            cnt             <= '0;
            carry           <= 1'b0;
            sub_q           <= 1'b0;
            bad             <= 1'b0;
            bus.start_ready <= 1'b1;
            bus.done_valid  <= 1'b0;
            bus.result      <= '0;
            bus.carry_out   <= 1'b0;
            bus.neg         <= 1'b0;
            bus.invalid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_sr            <= bus.a;
                        b_sr            <= bus.b;
                        sub_q           <= bus.sub;
                        carry           <= bus.sub;
                        cnt             <= '0;
                        bad             <= 1'b0;
                        acc             <= '0;
                        bus.start_ready <= 1'b0;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT_W;
                    b_sr  <= b_sr >> DIGIT_W;
                    acc   <= acc_nxt;
                    carry <= dcout;
                    bad   <= bad_nxt;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        // Any illegal digit suppresses the arithmetic result entirely.
                        bus.done_valid <= 1'b1;
                        bus.invalid    <= bad_nxt;
                        bus.result     <= bad_nxt ? '0 : acc_nxt;
                        bus.carry_out  <= !bad_nxt && !sub_q && dcout;
                        bus.neg        <= !bad_nxt && sub_q && !dcout;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        bus.done_valid  <= 1'b0;
                        bus.start_ready <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state           <= IDLE;
                    bus.start_ready <= 1'b1;
                    bus.done_valid  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4): integer reference model, latency, hold and reset checks.
module tb_bcd_serial_adder;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] result;
        logic         carry_out;
        logic         neg;
        logic         invalid;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb[$];

    bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        exp_t e;
        int   ai, bi, r, m;
        logic bad;
        logic [3:0] d;
        ai = 0; bi = 0; m = 1; bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = av[4*i +: 4]; bad |= (d > 4'd9); ai = ai * 10 + int'(d);
            d = bv[4*i +: 4]; bad |= (d > 4'd9); bi = bi * 10 + int'(d);
            m = m * 10;
        end
        e = '0;
        if (bad) begin
            e.invalid = 1'b1;
            return e;
        end
        if (sv) begin
            r     = ai - bi;
            e.neg = (r < 0);
            if (r < 0) r = r + m;
        end else begin
            r           = ai + bi;
            e.carry_out = (r >= m);
            if (r >= m) r = r - m;
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            e.result[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return e;
    endfunction

    // Drive one request, then hold off done_ready for 'hold' cycles before completing.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input int hold);
        int   lat;
        exp_t got, exp;
        @(negedge clk);
        chk("start_ready_idle", 32'(bus.start_ready), 32'd1);
        bus.a = av; bus.b = bv; bus.sub = sv; bus.start_valid = 1'b1;
        sb.push_back(model(av, bv, sv));
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        chk("start_ready_busy", 32'(bus.start_ready), 32'd0);
        lat = 0;
        while (!bus.done_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(DIGITS));
        exp = sb.pop_front();
        if (!bus.done_valid) return;
        got = '{bus.result, bus.carry_out, bus.neg, bus.invalid};
        chk("result",    32'(got.result),    32'(exp.result));
        chk("carry_out", 32'(got.carry_out), 32'(exp.carry_out));
        chk("neg",       32'(got.neg),       32'(exp.neg));
        chk("invalid",   32'(got.invalid),   32'(exp.invalid));
        for (int i = 0; i < hold; i++) begin
            bus.start_valid = 1'b1;
            bus.a = ~av; bus.b = bv; bus.sub = ~sv;
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.done_valid), 32'd1);
            chk("hold_ready", 32'(bus.start_ready), 32'd0);
            chk("hold_outs", 32'({bus.result, bus.carry_out, bus.neg, bus.invalid}), 32'(got));
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b1;
        @(posedge clk); #1;
        bus.done_ready = 1'b0;
        chk("post_hs_valid", 32'(bus.done_valid), 32'd0);
        chk("post_hs_ready", 32'(bus.start_ready), 32'd1);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < int'(DIGITS); i++) v[4*i +: 4] = 4'($urandom_range(9, 0));
        return v;
    endfunction

    initial begin
        int seen;
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.start_valid = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.done_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
        chk("rst_done_valid",  32'(bus.done_valid),  32'd0);
        chk("rst_outs", 32'({bus.result, bus.carry_out, bus.neg, bus.invalid}), 32'd0);
        rst_n = 1'b1;

        run_op(16'h0999, 16'h0001, 1'b0, 0);
        run_op(16'h9999, 16'h0001, 1'b0, 0);
        run_op(16'h0500, 16'h0123, 1'b1, 0);
        run_op(16'h0123, 16'h0500, 1'b1, 3);
        run_op(16'h4321, 16'h4321, 1'b1, 0);
        run_op(16'h00A1, 16'h0001, 1'b0, 0);
        run_op(16'h1234, 16'h00F0, 1'b1, 1);
        run_op(16'h0000, 16'h0000, 1'b0, 0);
        run_op(16'h0000, 16'h9999, 1'b1, 0);

        // Abort a request mid-RUN; it must never complete.
        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_ready", 32'(bus.start_ready), 32'd1);
        chk("abort_valid", 32'(bus.done_valid),  32'd0);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done_valid) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_op(16'h0458, 16'h0762, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
